// File: rtl/vmon_wb_pkg.sv
// vmon_wb_pkg: shared register offsets, FSM states and byte-lane decode for the vmon m2h endpoint.
package vmon_wb_pkg;
  localparam int REG_DATA_OFS = 0;
  localparam int REG_STATUS_OFS = 4;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, UNPACK, RESP} state_e;

  typedef struct packed {
    logic            legal;
    logic [2:0]      n;
    logic [3:0][1:0] lane;
  } sel_info_t;

  // Lanes are listed lowest first; only naturally aligned 1/2/4-byte selects are accepted.
  function automatic sel_info_t sel_decode(input logic [3:0] sel);
    sel_info_t r;
    r = '0;
    r.legal = 1'b1;
    r.n = 3'd1;
    case (sel)
      4'b0001: r.lane[0] = 2'd0;
      4'b0010: r.lane[0] = 2'd1;
      4'b0100: r.lane[0] = 2'd2;
      4'b1000: r.lane[0] = 2'd3;
      4'b0011: begin r.n = 3'd2; r.lane[0] = 2'd0; r.lane[1] = 2'd1; end
      4'b1100: begin r.n = 3'd2; r.lane[0] = 2'd2; r.lane[1] = 2'd3; end
      4'b1111: begin r.n = 3'd4; r.lane = {2'd3, 2'd2, 2'd1, 2'd0}; end
      default: begin r.legal = 1'b0; r.n = 3'd0; end
    endcase
    return r;
  endfunction
endpackage

// File: rtl/vmon_byte_fifo.sv
// vmon_byte_fifo: byte FIFO with simultaneous push/pop and an occupancy counter.
module vmon_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push,
  input  logic [7:0]               push_dat,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 4");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic          do_pop;

  assign do_pop = pop && !empty;
  assign empty  = level_q == '0;
  assign full   = level_q == LW'(DEPTH);
  assign level  = level_q;
  // Gate the head so the stream shows 0 rather than stale storage when empty.
  assign head   = empty ? 8'h00 : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      level_q <= level_q + LW'(push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= push_dat;
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i) assert (!(push && full));
  end
endmodule

// File: rtl/wb_vmon_m2h_endpoint.sv
// wb_vmon_m2h_endpoint: Wishbone slave terminating vmon mailbox writes into a byte FIFO
// that drains to the m2h valid/ready byte stream; STATUS exposes FIFO occupancy.
module wb_vmon_m2h_endpoint
  import vmon_wb_pkg::*;
#(
  parameter int                      WB_ADDR_WIDTH = 32,
  parameter int                      WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS      = '0,
  parameter int                      FIFO_DEPTH    = 64
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [WB_ADDR_WIDTH-1:0]     ADR,
  input  logic [WB_DATA_WIDTH-1:0]     DAT_W,
  output logic [WB_DATA_WIDTH-1:0]     DAT_R,
  input  logic                         CYC,
  input  logic                         STB,
  input  logic                         WE,
  input  logic [WB_DATA_WIDTH/8-1:0]   SEL,
  output logic                         ACK,
  output logic                         ERR,
  output logic [7:0]                   m2h_dat,
  output logic                         m2h_valid,
  input  logic                         m2h_ready,
  output logic [$clog2(FIFO_DEPTH):0]  level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  if (WB_DATA_WIDTH != 32) begin : g_bad_dw
    $error("WB_DATA_WIDTH must be 32");
  end

  state_e        state_q, state_d;
  sel_info_t     sel_q, sel_d, dec;
  logic [31:0]   dat_q, dat_d, dat_r_q, dat_r_d;
  logic [1:0]    idx_q, idx_d;
  logic          ack_q, ack_d, err_q, err_d;
  logic          req, hit, is_status, push, full, empty;
  logic [7:0]    push_dat;
  logic [LW-1:0] space;
  logic          unused_adr;

  assign unused_adr = ^ADR[1:0];
  assign req        = CYC && STB;
  assign hit        = req && ADR[WB_ADDR_WIDTH-1:3] == ADDRESS[WB_ADDR_WIDTH-1:3];
  assign is_status  = ADR[2] == 1'(REG_STATUS_OFS >> 2);
  assign dec        = sel_decode(SEL);
  assign space      = LW'(FIFO_DEPTH) - level;
  assign push_dat   = dat_q[{sel_q.lane[idx_q], 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    dat_r_d = dat_r_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: if (hit) begin
        if (is_status) begin
          ack_d   = 1'b1;
          dat_r_d = WE ? 32'h0 : {full, empty, {(30-LW){1'b0}}, level};
          state_d = RESP;
        end else if (WE && dec.legal) begin
          sel_d   = dec;
          dat_d   = DAT_W;
          idx_d   = 2'd0;
          state_d = space >= LW'(dec.n) ? UNPACK : WAIT_SPACE;
        end else begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT_SPACE: state_d = !req ? IDLE : (space >= LW'(sel_q.n) ? UNPACK : WAIT_SPACE);
      UNPACK: begin
        push  = 1'b1;
        idx_d = idx_q + 2'd1;
        if ({1'b0, idx_q} == sel_q.n - 3'd1) begin
          ack_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        dat_r_d = 32'h0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dat_q   <= '0;
      dat_r_q <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      dat_r_q <= dat_r_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ACK       = ack_q;
  assign ERR       = err_q;
  assign DAT_R     = dat_r_q;
  assign m2h_valid = !empty;

  vmon_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .push     (push),
    .push_dat (push_dat),
    .pop      (m2h_valid && m2h_ready),
    .head     (m2h_dat),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );
endmodule

// File: tb/tb_wb_vmon_m2h_endpoint.sv
// tb_wb_vmon_m2h_endpoint: directed self-checking bench for the vmon m2h endpoint.
module tb_wb_vmon_m2h_endpoint;
  logic        clk = 1'b0;
  logic        rstn_i;
  logic [31:0] ADR, DAT_W, DAT_R;
  logic        CYC, STB, WE, ACK, ERR;
  logic [3:0]  SEL;
  logic [7:0]  m2h_dat;
  logic        m2h_valid, m2h_ready;
  logic [6:0]  level;

  int checks = 0;
  int failures = 0;
  int lat;
  logic r_ack, r_err;
  logic [31:0] r_dat;
  logic [7:0] got[$];
  int max_level;

  localparam logic [31:0] DW = 32'hDDCCBBAA;
  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;

  always #5 clk = ~clk;

  wb_vmon_m2h_endpoint dut (
    .clk_i(clk), .rstn_i(rstn_i), .ADR(ADR), .DAT_W(DAT_W), .DAT_R(DAT_R),
    .CYC(CYC), .STB(STB), .WE(WE), .SEL(SEL), .ACK(ACK), .ERR(ERR),
    .m2h_dat(m2h_dat), .m2h_valid(m2h_valid), .m2h_ready(m2h_ready), .level(level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds the request until ACK/ERR or a 200-cycle budget.
  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int l, output logic a, output logic e,
                          output logic [31:0] rd);
    ADR = adr; DAT_W = dat; SEL = sel; WE = we; CYC = 1'b1; STB = 1'b1;
    l = 0; a = 1'b0; e = 1'b0; rd = 32'h0;
    for (int i = 1; i <= 200 && !(a || e); i++) begin
      @(negedge clk);
      if (ACK || ERR) begin l = i; a = ACK; e = ERR; rd = DAT_R; end
    end
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input int exp_lat, input logic exp_ack, input logic [31:0] exp_rd);
    wb_cycle(we, adr, DW, sel, lat, r_ack, r_err, r_dat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_ack"}, r_ack, exp_ack);
    chk({tag, "_err"}, r_err, !exp_ack);
    chk({tag, "_rdat"}, r_dat, exp_rd);
    @(negedge clk);
    chk({tag, "_pulse"}, {ACK, ERR}, 2'b00);
    chk({tag, "_datr_clr"}, DAT_R, 32'h0);
  endtask

  task automatic drain(input string tag, input logic [31:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, m2h_valid, 1'b1);
      chk({tag, "_byte"}, m2h_dat, bytes[8*i +: 8]);
      m2h_ready = 1'b1;
      @(negedge clk);
      m2h_ready = 1'b0;
    end
    chk({tag, "_empty"}, m2h_valid, 1'b0);
  endtask

  initial begin
    rstn_i = 1'b0; ADR = A_STAT; DAT_W = 32'h0; SEL = 4'hF; WE = 1'b0;
    CYC = 1'b1; STB = 1'b1; m2h_ready = 1'b0;
    // 1. reset with a live request
    repeat (3) @(negedge clk);
    chk("rst_ack", ACK, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_valid", m2h_valid, 1'b0);
    chk("rst_level", level, 7'd0);
    chk("rst_datr", DAT_R, 32'h0);
    chk("rst_dat", m2h_dat, 8'h00);
    rstn_i = 1'b1; CYC = 1'b0; STB = 1'b0;
    repeat (3) @(negedge clk);
    chk("rel_noresp", {ACK, ERR}, 2'b00);

    // miss: no response, no push
    ADR = 32'h10; WE = 1'b1; SEL = 4'hF; CYC = 1'b1; STB = 1'b1;
    repeat (4) @(negedge clk);
    chk("miss_noresp", {ACK, ERR}, 2'b00);
    chk("miss_level", level, 7'd0);
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    @(negedge clk);

    // 2. byte lanes
    txn("w1111", 1'b1, A_DATA, 4'b1111, 5, 1'b1, 32'h0);
    chk("w1111_level", level, 7'd4);
    drain("s1111", 32'hDDCCBBAA, 4);
    txn("w1100", 1'b1, A_DATA, 4'b1100, 3, 1'b1, 32'h0);
    chk("w1100_level", level, 7'd2);
    drain("s1100", 32'h0000DDCC, 2);
    txn("w0010", 1'b1, A_DATA, 4'b0010, 2, 1'b1, 32'h0);
    drain("s0010", 32'h000000BB, 1);
    txn("w0011", 1'b1, A_DATA, 4'b0011, 3, 1'b1, 32'h0);
    drain("s0011", 32'h0000BBAA, 2);

    // 3. error responses and status
    txn("ill0101", 1'b1, A_DATA, 4'b0101, 1, 1'b0, 32'h0);
    chk("ill_level", level, 7'd0);
    txn("dread", 1'b0, A_DATA, 4'b1111, 1, 1'b0, 32'h0);
    chk("dread_level", level, 7'd0);
    txn("st_empty", 1'b0, A_STAT, 4'b1111, 1, 1'b1, 32'h4000_0000);
    txn("st_write", 1'b1, A_STAT, 4'b1111, 1, 1'b1, 32'h0);
    chk("st_write_level", level, 7'd0);

    // 4. backpressure
    for (int k = 0; k < 15; k++) txn("fill", 1'b1, A_DATA, 4'b1111, 5, 1'b1, 32'h0);
    txn("fill2", 1'b1, A_DATA, 4'b1100, 3, 1'b1, 32'h0);
    chk("fill_level", level, 7'd62);
    txn("st_62", 1'b0, A_STAT, 4'b1111, 1, 1'b1, 32'h0000_003E);
    fork
      wb_cycle(1'b1, A_DATA, DW, 4'b1111, lat, r_ack, r_err, r_dat);
      begin
        repeat (4) @(negedge clk);
        chk("stall_noack", {ACK, ERR}, 2'b00);
        chk("stall_level", level, 7'd62);
        m2h_ready = 1'b1;
        repeat (2) @(negedge clk);
        m2h_ready = 1'b0;
      end
    join
    chk("bp_ack", r_ack, 1'b1);
    chk("bp_err", r_err, 1'b0);
    chk("bp_level", level, 7'd64);
    @(negedge clk);
    txn("st_full", 1'b0, A_STAT, 4'b1111, 1, 1'b1, 32'h8000_0040);
    m2h_ready = 1'b1;
    repeat (70) @(negedge clk);
    m2h_ready = 1'b0;
    chk("bp_drained", level, 7'd0);

    // 5. streaming while writing
    got = {};
    max_level = 0;
    m2h_ready = 1'b1;
    fork
      wb_cycle(1'b1, A_DATA, DW, 4'b1111, lat, r_ack, r_err, r_dat);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (int'(level) > max_level) max_level = int'(level);
        if (m2h_valid) got.push_back(m2h_dat);
      end
    join
    m2h_ready = 1'b0;
    chk("thr_lat", lat, 5);
    chk("thr_maxlvl", max_level, 1);
    chk("thr_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("thr_byte", got[i], DW[8*i +: 8]);
    chk("thr_level", level, 7'd0);

    // 6. reset mid-UNPACK
    @(negedge clk);
    ADR = A_DATA; DAT_W = DW; SEL = 4'hF; WE = 1'b1; CYC = 1'b1; STB = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_level2", level, 7'd2);
    rstn_i = 1'b0; CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    @(negedge clk);
    chk("mid_noack", {ACK, ERR}, 2'b00);
    chk("mid_level", level, 7'd0);
    chk("mid_valid", m2h_valid, 1'b0);
    rstn_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_after", {ACK, ERR, m2h_valid}, 3'b000);
    txn("post", 1'b1, A_DATA, 4'b0001, 2, 1'b1, 32'h0);
    drain("spost", 32'h000000AA, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
